// File: rtl/psg_multichannel.sv
// rtl/psg_multichannel.sv - multichannel programmable sound generator with tone/noise channels, mixer and PWM output
module psg_multichannel #(
    parameter int NUM_TONES   = 3,
    parameter int FREQ_BITS   = 10,
    parameter int CHAN_BITS   = 8,
    parameter int MASTER_BITS = 7,
    parameter int CLK_DIV     = 16,
    parameter int LFSR_BITS   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [FREQ_BITS-1:0]   wr_data,
    output logic [MASTER_BITS-1:0] sample,
    output logic                   tick,
    output logic                   pwm_out
);
    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NCW = (FREQ_BITS > 7) ? FREQ_BITS : 7;
    localparam int SW  = CHAN_BITS + $clog2(NUM_TONES + 1);
    localparam logic [LFSR_BITS-1:0] LFSR_SEED = {1'b1, {(LFSR_BITS-1){1'b0}}};
    localparam logic [CHAN_BITS-1:0] VOL_MAX   = {CHAN_BITS{1'b1}};
    localparam logic [CHAN_BITS+17:0] VOL_MAX_W = {18'b0, {CHAN_BITS{1'b1}}};
    localparam logic [CHAN_BITS+17:0] HALF_LSB  = {{(CHAN_BITS+2){1'b0}}, 1'b1, 15'b0};

    logic [PW-1:0]          pre_cnt;
    logic                   tick_int;
    logic [FREQ_BITS-1:0]   tone_period [NUM_TONES];
    logic [3:0]             tone_attn   [NUM_TONES];
    logic [FREQ_BITS-1:0]   tone_cnt    [NUM_TONES];
    logic [NUM_TONES-1:0]   tone_ff;
    logic [NUM_TONES-1:0]   tone_out;
    logic [2:0]             noise_ctrl;
    logic [3:0]             noise_attn;
    logic [NCW-1:0]         noise_cnt;
    logic [NCW-1:0]         noise_half;
    logic                   noise_clk;
    logic                   noise_wr;
    logic                   lfsr_fb;
    logic [LFSR_BITS-1:0]   lfsr;
    logic [SW-1:0]          mix_sum;
    logic [CHAN_BITS-1:0]   mix_clamp;
    logic [MASTER_BITS-1:0] pwm_cnt;
    logic [MASTER_BITS-1:0] duty;

    // Volume = round((2^CHAN_BITS-1) * 10^(-attn/10)); scale factors are 10^(-attn/10) in Q16.
    function automatic logic [CHAN_BITS-1:0] atten_vol(input logic [3:0] attn);
        logic [16:0]          scale;
        logic [CHAN_BITS+17:0] prod;
        case (attn)
            4'd0:    scale = 17'd65536;
            4'd1:    scale = 17'd52057;
            4'd2:    scale = 17'd41350;
            4'd3:    scale = 17'd32846;
            4'd4:    scale = 17'd26090;
            4'd5:    scale = 17'd20724;
            4'd6:    scale = 17'd16462;
            4'd7:    scale = 17'd13076;
            4'd8:    scale = 17'd10387;
            4'd9:    scale = 17'd8250;
            4'd10:   scale = 17'd6554;
            4'd11:   scale = 17'd5206;
            4'd12:   scale = 17'd4135;
            4'd13:   scale = 17'd3285;
            4'd14:   scale = 17'd2609;
            default: scale = 17'd0;
        endcase
        prod = VOL_MAX_W * {{(CHAN_BITS+1){1'b0}}, scale} + HALF_LSB;
        return CHAN_BITS'(prod >> 16);
    endfunction

    assign tick_int = (pre_cnt == PW'(CLK_DIV - 1));
    assign tick     = tick_int & ~reset;
    assign noise_wr = wr_en & (wr_addr == 4'd7);

    // Prescaler: free-running 0..CLK_DIV-1, generators advance on the terminal count.
    always_ff @(posedge clk) begin
        if (reset || tick_int) pre_cnt <= '0;
        else                   pre_cnt <= pre_cnt + 1'b1;
    end

    // Register file; unmapped addresses fall through every compare and change nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < NUM_TONES; a++) begin
                tone_period[a] <= '0;
                tone_attn[a]   <= 4'hf;
            end
            noise_ctrl <= 3'b100;
            noise_attn <= 4'hf;
        end else if (wr_en) begin
            for (int a = 0; a < NUM_TONES; a++) begin
                if (wr_addr == 4'(a))     tone_period[a] <= wr_data;
                if (wr_addr == 4'(8 + a)) tone_attn[a]   <= wr_data[3:0];
            end
            if (wr_addr == 4'd7)  noise_ctrl <= wr_data[2:0];
            if (wr_addr == 4'd15) noise_attn <= wr_data[3:0];
        end
    end

    // Tone generators; the >= compare makes a shrinking period toggle on the next tick instead of wrapping.
    always_ff @(posedge clk) begin
        for (int a = 0; a < NUM_TONES; a++) begin
            if (reset) begin
                tone_cnt[a] <= '0;
                tone_ff[a]  <= 1'b0;
            end else if (tone_period[a] == '0) begin
                tone_cnt[a] <= '0;
            end else if (tick_int) begin
                if (tone_cnt[a] >= tone_period[a] - 1'b1) begin
                    tone_cnt[a] <= '0;
                    tone_ff[a]  <= ~tone_ff[a];
                end else begin
                    tone_cnt[a] <= tone_cnt[a] + 1'b1;
                end
            end
        end
    end

    // Channel outputs: period 0 is DC high; noise half-period select and feedback tap.
    always_comb begin
        for (int a = 0; a < NUM_TONES; a++)
            tone_out[a] = (tone_period[a] == '0) | tone_ff[a];
        case (noise_ctrl[1:0])
            2'd0:    noise_half = NCW'(16);
            2'd1:    noise_half = NCW'(32);
            2'd2:    noise_half = NCW'(64);
            default: noise_half = (tone_period[NUM_TONES-1] == '0) ? NCW'(1)
                                                                   : NCW'(tone_period[NUM_TONES-1]);
        endcase
        lfsr_fb = noise_ctrl[2] ? (lfsr[0] ^ lfsr[3]) : lfsr[0];
    end

    // Noise generator: the LFSR steps when the internal noise clock rises; a control write restarts it.
    always_ff @(posedge clk) begin
        if (reset || noise_wr) begin
            noise_cnt <= '0;
            noise_clk <= 1'b0;
            lfsr      <= LFSR_SEED;
        end else if (tick_int) begin
            if (noise_cnt >= noise_half - 1'b1) begin
                noise_cnt <= '0;
                noise_clk <= ~noise_clk;
                if (!noise_clk) lfsr <= {lfsr_fb, lfsr[LFSR_BITS-1:1]};
            end else begin
                noise_cnt <= noise_cnt + 1'b1;
            end
        end
    end

    // Mixer: full-width sum of gated volumes, clamped to the channel full scale.
    always_comb begin
        mix_sum = '0;
        for (int a = 0; a < NUM_TONES; a++)
            if (tone_out[a]) mix_sum = mix_sum + SW'(atten_vol(tone_attn[a]));
        if (lfsr[0]) mix_sum = mix_sum + SW'(atten_vol(noise_attn));
        mix_clamp = (mix_sum > SW'(VOL_MAX)) ? VOL_MAX : mix_sum[CHAN_BITS-1:0];
    end

    // Output sample register: top MASTER_BITS of the clamped mix.
    always_ff @(posedge clk) begin
        if (reset) sample <= '0;
        else       sample <= mix_clamp[CHAN_BITS-1 -: MASTER_BITS];
    end

    // PWM: duty only reloads at counter wrap so each period is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) duty <= sample;
            pwm_out <= (pwm_cnt < duty);
        end
    end
endmodule

// File: tb/tb_psg_multichannel.sv
// tb/tb_psg_multichannel.sv - self-checking bench for psg_multichannel
module tb_psg_multichannel;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [9:0] wr_data = 10'd0;
    logic [6:0] sample, sample16;
    logic       tick, tick16, pwm_out, pwm16;

    psg_multichannel #(.CLK_DIV(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sample(sample), .tick(tick), .pwm_out(pwm_out)
    );

    psg_multichannel u16 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sample(sample16), .tick(tick16), .pwm_out(pwm16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    typedef struct {
        string name;
        int    due;
        int    exp;
    } sb_t;
    sb_t sbq[$];

    // Scoreboard: each expected sample is due one edge after its write edge.
    always @(negedge clk) begin
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check(e.name, int'(sample), e.exp);
        end
    end

    typedef struct {
        logic [3:0] addr;
        logic [9:0] data;
        int         exp;
    } vec_t;
    vec_t vecs[$];

    task automatic wr(input logic [3:0] a, input logic [9:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int sweep[16] = '{127, 101, 80, 64, 51, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 0};
    int ts[48];
    int tr[$];
    int hi, gap, nint, last, bad, r1, r2, w, ones, found;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with a concurrent write that must be ignored
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_sample", int'(sample), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_sample16", int'(sample16), 0);
        check("rst_tick16", int'(tick16), 0);
        check("rst_pwm16", int'(pwm16), 0);
        reset = 1'b0; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("write_in_reset", int'(sample), 0);

        // prescaler period on the CLK_DIV=16 instance
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (tick16) found = 1;
        end
        @(negedge clk);
        check("tick16_width", int'(tick16), 0);
        gap = 1;
        while (!tick16 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        check("tick16_period", gap, 16);

        // table: attenuation sweep, masking, unmapped addresses, clamp
        for (int k = 0; k < 16; k++) vecs.push_back('{4'd8, 10'(k), sweep[k]});
        vecs.push_back('{4'd8,  10'h3F5, 40});
        vecs.push_back('{4'd5,  10'd0,   40});
        vecs.push_back('{4'd4,  10'd0,   40});
        vecs.push_back('{4'd12, 10'd0,   40});
        vecs.push_back('{4'd8,  10'd0,   127});
        vecs.push_back('{4'd9,  10'd0,   127});
        vecs.push_back('{4'd10, 10'd0,   127});
        vecs.push_back('{4'd9,  10'd15,  127});
        vecs.push_back('{4'd10, 10'd15,  127});
        vecs.push_back('{4'd8,  10'd3,   64});
        vecs.push_back('{4'd9,  10'd3,   127});
        vecs.push_back('{4'd9,  10'd4,   115});
        vecs.push_back('{4'd9,  10'd15,  64});
        vecs.push_back('{4'd8,  10'd0,   127});
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
            sbq.push_back('{$sformatf("vec%0d_a%0d_d%0d", i, vecs[i].addr, vecs[i].data), cyc + 2, vecs[i].exp});
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);

        // PWM duty with sample held at 127
        repeat (300) @(negedge clk);
        check("sample16_dc", int'(sample16), 127);
        hi = 0;
        repeat (128) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        check("pwm_duty", hi, 127);

        // tone 0 period 4: square wave with 4-cycle half period
        wr(4'd0, 10'd4);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            ts[i] = int'(sample);
        end
        bad = 0; nint = 0; last = -1;
        for (int i = 0; i < 48; i++) if (ts[i] != 0 && ts[i] != 127) bad++;
        check("tone_levels", bad, 0);
        for (int i = 1; i < 48; i++) begin
            if (ts[i] != ts[i-1]) begin
                if (last >= 0 && nint < 6) begin
                    check($sformatf("tone_interval%0d", nint), i - last, 4);
                    nint++;
                end
                last = i;
            end
        end
        check("tone_intervals_seen", nint, 6);

        // periodic noise, half-period 16
        wr(4'd8, 10'd15);
        wr(4'd0, 10'd0);
        wr(4'd7, 10'd0);
        wr(4'd15, 10'd0);
        for (int k = 3; k <= 1100; k++) begin
            @(negedge clk);
            tr.push_back((sample == 7'd127) ? 1 : 0);
        end
        r1 = -1; r2 = -1; w = 0; ones = 0;
        for (int i = 0; i < tr.size(); i++) ones += tr[i];
        for (int i = 0; i < tr.size() && r1 < 0; i++) if (tr[i] == 1) r1 = i;
        if (r1 >= 0) begin
            for (int i = r1; i < tr.size() && tr[i] == 1; i++) w++;
            for (int i = r1 + w; i < tr.size() && r2 < 0; i++) if (tr[i] == 1) r2 = i;
        end
        check("noise_first_high", r1 + 3, 465);
        check("noise_high_width", w, 32);
        check("noise_second_high", r2 + 3, 977);
        check("noise_high_cycles", ones, 64);

        // restart via control write mid-run
        wr(4'd7, 10'd0);
        check("noise_restart_low", int'(sample), 0);
        r1 = -1;
        for (int k = 1; k <= 600 && r1 < 0; k++) begin
            @(negedge clk);
            if (sample == 7'd127) r1 = k;
        end
        check("noise_restart_first_high", r1, 465);

        // mid-operation reset overrides a concurrent write
        wr(4'd15, 10'd15);
        wr(4'd8, 10'd0);
        repeat (3) @(negedge clk);
        check("pre_reset_sample", int'(sample), 127);
        @(negedge clk);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd8; wr_data = 10'd5;
        @(negedge clk);
        check("mid_reset_sample", int'(sample), 0);
        check("mid_reset_pwm", int'(pwm_out), 0);
        check("mid_reset_tick", int'(tick), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_sample", int'(sample), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/psg_multichannel.md
PSG_MULTICHANNEL -- requirements
Module: psg_multichannel

Interface
REQ-001 The module SHALL have parameter NUM_TONES, default 3: number of tone channels, legal range 1..7; one noise channel is always present.
REQ-002 The module SHALL have parameter FREQ_BITS, default 10: width of the tone period registers and counters.
REQ-003 The module SHALL have parameter CHAN_BITS, default 8: width of each channel volume after attenuation.
REQ-004 The module SHALL have parameter MASTER_BITS, default 7: width of the mixed sample and of the PWM counter.
REQ-005 The module SHALL have parameter CLK_DIV, default 16: clk cycles per generator tick; 1 means a tick every cycle.
REQ-006 The module SHALL have parameter LFSR_BITS, default 16: noise shift-register width.
REQ-007 The module SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-008 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The module SHALL have port wr_en, input, 1 bit: register-write strobe, sampled every cycle.
REQ-010 The module SHALL have port wr_addr, input, 4 bits: register address.
REQ-011 The module SHALL have port wr_data, input, FREQ_BITS bits: write data, LSB-aligned.
REQ-012 The module SHALL have port sample, output, MASTER_BITS bits: registered mixed sample.
REQ-013 The module SHALL have port tick, output, 1 bit: one-cycle pulse on each generator tick.
REQ-014 The module SHALL have port pwm_out, output, 1 bit: PWM rendering of sample.

Function
REQ-015 Register map: addr a < NUM_TONES = tone a period; addr 7 = noise control, bits [2:0]; addr 8+a = tone a attenuation, bits [3:0]; addr 15 = noise attenuation, bits [3:0]; all other addresses SHALL be ignored with no side effect.
REQ-016 A write SHALL take effect at the rising edge where wr_en=1; unused high wr_data bits SHALL be ignored.
REQ-017 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be 1 in the cycle the count equals CLK_DIV-1.
REQ-018 Tone, period P=0: output SHALL be a constant 1 and the counter SHALL hold at 0.
REQ-019 Tone, P>=1: on each tick, if counter >= P-1 then counter SHALL go to 0 and output SHALL toggle; otherwise counter SHALL increment. Half-period = P ticks.
REQ-020 Lowering P below the current count SHALL cause a toggle and counter clear on the next tick; no wrap through 2^FREQ_BITS.
REQ-021 Noise half-period in ticks SHALL be selected by control[1:0]: 00=16, 01=32, 10=64, 11=period of tone NUM_TONES-1 (0 treated as 1).
REQ-022 The LFSR SHALL shift right once per rising edge of the internal noise clock; feedback SHALL be lfsr[0]^lfsr[3] when control[2]=1 (white), else lfsr[0] (periodic); noise output SHALL equal lfsr[0].
REQ-023 A write to addr 7 SHALL reload the LFSR to 1<<(LFSR_BITS-1) and clear the noise counter and noise clock in the same edge.
REQ-024 Attenuation: a channel's volume SHALL be 0 when its output is 0, else round((2^CHAN_BITS-1)*10^(-attn/10)) for attn 0..14, and 0 for attn 15. For CHAN_BITS=8 the table SHALL be: 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0.
REQ-025 The mixer SHALL sum all NUM_TONES+1 volumes at full width CHAN_BITS+clog2(NUM_TONES+1) and SHALL clamp the sum to 2^CHAN_BITS-1.
REQ-026 sample SHALL be registered as clamp[CHAN_BITS-1 -: MASTER_BITS] and SHALL reflect state one edge after the generator/register update: a write at edge E appears on sample after edge E+1.
REQ-027 The PWM counter SHALL free-run over 0..2^MASTER_BITS-1; the duty value SHALL be latched from sample only when the counter wraps to 0; pwm_out SHALL be registered as counter < latched duty.
REQ-028 A simultaneous write and tick SHALL apply the tick using the old register value; the new value SHALL govern from the next tick.

Reset
REQ-029 While reset=1: tone periods SHALL be 0, all attenuations 15, noise control 3'b100, LFSR 1<<(LFSR_BITS-1), all counters, prescaler and tone outputs 0, sample 0, tick 0, pwm_out 0, latched duty 0.
REQ-030 A reset asserted mid-operation SHALL override any concurrent write; the state of REQ-029 SHALL hold from the first edge after assertion.

Verification
REQ-031 Reset, then write addr 8 with 0 (tone 0 period 0, DC high) -> sample=127 after 2 edges; with all other channels silent, pwm_out duty = 127/128.
REQ-032 CLK_DIV=1, tone 0 period 4, attn 0 -> tone output toggles every 4 cycles; sample alternates between 0 and 127.
REQ-033 All four channels period 0, attn 0 -> raw sum 1020 is clamped to 255 -> sample=127, no wrap.
REQ-034 Sweep tone 0 attenuation 0..15 with DC output -> sample equals table>>1: 127,101,80,64,51,40,32,25,20,16,13,10,8,6,5,0.
REQ-035 Periodic noise, control=3'b000, CLK_DIV=1 -> noise output is a single 1 every 16 shifts (period 512 cycles); a write to addr 7 mid-run restarts the sequence from the reload value.
REQ-036 Writes to unmapped addresses (e.g. addr 5 with NUM_TONES=3) and to any address while reset=1 -> no change to any register or output.
